// File: rtl/dct_pkg.sv
// Shared types and constants for the 2D DCT datapath.
// Holds block geometry, stage widths and the transpose bank state.
package dct_pkg;

  localparam int DCT_N     = 8;
  localparam int BW_STAGE1 = 11;
  localparam int BW_STAGE2 = 12;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_e;

endpackage

// File: rtl/tp_bank.sv
// One NxN element bank of the transpose buffer.
// Row-write port plus combinational row and column read ports.
module tp_bank
  import dct_pkg::*;
#(
  parameter int BW = BW_STAGE1,
  parameter int N  = DCT_N,
  localparam int LW = clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [LW-1:0] wrow,
  input  logic [N*BW-1:0] wdata,
  input  logic [LW-1:0] ridx,
  output logic [N*BW-1:0] col_data,
  output logic [N*BW-1:0] row_data
);

  logic [N*BW-1:0] mem [N];

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem[wrow] <= wdata;
  end

  always_comb begin
    col_data = '0;
    for (int k = 0; k < N; k++) begin
      col_data[k*BW +: BW] = mem[k][ridx*BW +: BW];
    end
  end

  assign row_data = mem[ridx];

endmodule

// File: rtl/tp_pingpong_buf.sv
// Double-buffered transpose memory between row and column DCT.
// Two banks alternate fill/drain; per-block bypass passes rows.
module tp_pingpong_buf
  import dct_pkg::*;
#(
  parameter int BW = BW_STAGE1,
  parameter int N  = DCT_N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic          i_bypass,
  input  logic [N*BW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [N*BW-1:0] o_data,
  output logic          o_first,
  output logic          o_last
);

  localparam int LW = clog2(N);
  localparam logic [LW-1:0] LAST = LW'(N-1);

  bank_st_e      st_q [2];
  bank_st_e      st_d [2];
  logic [1:0]    mode_q, mode_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [LW-1:0] wr_q, wr_d;
  logic [LW-1:0] rc_q, rc_d;

  logic          wr_fire;
  logic          rd_fire;
  logic [N*BW-1:0] col_v [2];
  logic [N*BW-1:0] row_v [2];

  assign wr_fire = i_valid && i_ready;
  assign rd_fire = o_valid && o_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tp_bank #(
      .BW(BW),
      .N (N)
    ) u_bank (
      .clk     (clk),
      .we      (wr_fire && !flush && (wb_q == 1'(b))),
      .wrow    (wr_q),
      .wdata   (i_data),
      .ridx    (rc_q),
      .col_data(col_v[b]),
      .row_data(row_v[b])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      mode_q  <= '0;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      wr_q    <= '0;
      rc_q    <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      mode_q  <= mode_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wr_q    <= wr_d;
      rc_q    <= rc_d;
    end
  end

  // fill and drain always touch opposite banks
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    mode_d  = mode_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    wr_d    = wr_q;
    rc_d    = rc_q;
    if (flush) begin
      st_d[0] = EMPTY;
      st_d[1] = EMPTY;
      wb_d    = 1'b0;
      rb_d    = 1'b0;
      wr_d    = '0;
      rc_d    = '0;
    end else begin
      if (wr_fire) begin
        wr_d = wr_q + 1'b1;
        unique case (1'b1)
          (wr_q == '0): begin
            st_d[wb_q]   = FILLING;
            mode_d[wb_q] = i_bypass;
          end
          (wr_q == LAST): begin
            st_d[wb_q] = FULL;
            wb_d       = ~wb_q;
          end
          default: ;
        endcase
      end
      if (rd_fire) begin
        rc_d = rc_q + 1'b1;
        if (rc_q == LAST) begin
          st_d[rb_q] = EMPTY;
          rb_d       = ~rb_q;
        end
      end
    end
  end

  always_comb begin
    i_ready = (st_q[wb_q] != FULL);
    o_valid = (st_q[rb_q] == FULL);
    o_first = o_valid && (rc_q == '0);
    o_last  = o_valid && (rc_q == LAST);
    o_data  = '0;
    if (o_valid) begin
      o_data = mode_q[rb_q] ? row_v[rb_q] : col_v[rb_q];
    end
  end

endmodule

// File: tb/tb_tp_pingpong_buf.sv
// Bench for tp_pingpong_buf: directed plan steps plus random
// traffic against a block-level queue model.
module tb_tp_pingpong_buf;

  localparam int N  = 8;
  localparam int BW = 11;
  localparam int W  = N * BW;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic         i_bypass = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_data;
  logic         o_first;
  logic         o_last;

  always #5 clk = ~clk;

  tp_pingpong_buf #(
    .BW(BW),
    .N (N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_bypass(i_bypass),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_first (o_first),
    .o_last  (o_last)
  );

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] cur [N][N];
  int            wcnt = 0;
  logic          cur_byp = 1'b0;
  logic [W-1:0]  outq [$];

  int gblk = 0;
  int grow = 0;
  int byp_rows = 0;
  int macc = 0;
  int n_in = 0;
  int n_out = 0;
  int n_drop = 0;

  function automatic logic [W-1:0] mkrow(int b, int r);
    logic [W-1:0] v;
    for (int c = 0; c < N; c++) v[c*BW +: BW] = BW'(b*256 + r*16 + c);
    return v;
  endfunction

  function automatic logic [W-1:0] mkcol(int b, int c);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*BW +: BW] = BW'(b*256 + k*16 + c);
    return v;
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    outq.delete();
    wcnt = 0;
  endtask

  task automatic model_take(logic [W-1:0] d, logic byp);
    logic [W-1:0] v;
    if (wcnt == 0) cur_byp = byp;
    for (int c = 0; c < N; c++) cur[wcnt][c] = d[c*BW +: BW];
    wcnt++;
    if (wcnt == N) begin
      for (int c = 0; c < N; c++) begin
        v = '0;
        for (int k = 0; k < N; k++)
          v[k*BW +: BW] = cur_byp ? cur[c][k] : cur[k][c];
        outq.push_back(v);
      end
      wcnt = 0;
    end
  endtask

  task automatic cyc();
    logic         e_ir, e_ov, e_of, e_ol, inf, outf;
    logic [W-1:0] e_od;
    int           nf;
    #1;
    nf   = (outq.size() + N - 1) / N;
    e_ir = (nf < 2);
    e_ov = (outq.size() > 0);
    e_od = e_ov ? outq[0] : '0;
    e_of = e_ov && (outq.size() % N == 0);
    e_ol = e_ov && (outq.size() % N == 1);
    chk("i_ready", W'(i_ready), W'(e_ir));
    chk("o_valid", W'(o_valid), W'(e_ov));
    chk("o_data", o_data, e_od);
    chk("o_first", W'(o_first), W'(e_of));
    chk("o_last", W'(o_last), W'(e_ol));
    inf  = reset && !flush && i_valid && e_ir;
    outf = reset && !flush && e_ov && o_ready;
    if (i_valid && i_ready) n_in++;
    if (o_valid && o_ready) n_out++;
    if (!i_ready) n_drop++;
    @(posedge clk);
    if (!reset || flush) begin
      model_clear();
    end else begin
      if (outf) void'(outq.pop_front());
      if (inf) begin
        model_take(i_data, i_bypass);
        macc++;
        grow++;
        if (grow == N) begin
          grow = 0;
          gblk++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(logic v, logic r);
    i_valid  = v;
    o_ready  = r;
    i_data   = mkrow(gblk, grow);
    i_bypass = (grow < byp_rows);
    cyc();
  endtask

  task automatic feed(int n, logic r);
    int m0;
    m0 = macc;
    for (int i = 0; i < 8*n + 40 && macc - m0 < n; i++) step(1'b1, r);
    chk("feed_rows", W'(macc - m0), W'(n));
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    reset = 1'b1;

    // single transpose block
    gblk = 0; grow = 0;
    feed(8, 1'b1);
    #1;
    chk("t1_vec0", o_data, mkcol(0, 0));
    chk("t1_first", W'(o_first), W'(1'b1));
    repeat (10) step(1'b0, 1'b1);

    // four back-to-back blocks
    gblk = 0; grow = 0; n_out = 0; n_drop = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 7 || i == 8) begin
        #1;
        chk("t2_latency", W'(o_valid), W'(i == 8));
      end
      step(gblk < 4, 1'b1);
    end
    chk("t2_outputs", W'(n_out), W'(32));
    chk("t2_no_drop", W'(n_drop), W'(0));

    // stall after two outputs
    gblk = 0; grow = 0; n_out = 0; n_in = 0;
    for (int i = 0; i < 24; i++) step(1'b1, n_out < 2);
    chk("t3_accepted", W'(n_in), W'(16));
    chk("t3_iready", W'(i_ready), W'(1'b0));
    chk("t3_hold_a", o_data, mkcol(0, 2));
    step(1'b0, 1'b0);
    chk("t3_hold_b", o_data, mkcol(0, 2));
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1);
    chk("t3_total_out", W'(n_out), W'(16));

    // bypass block, toggle mid-block, then transpose block
    gblk = 0; grow = 0; byp_rows = 3;
    feed(8, 1'b0);
    byp_rows = 0;
    #1;
    chk("t4_byp_vec0", o_data, mkrow(0, 0));
    feed(8, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    chk("t4_tr_vec0", o_data, mkcol(1, 0));
    repeat (10) step(1'b0, 1'b1);

    // reset mid-block
    gblk = 4; grow = 0;
    feed(5, 1'b1);
    reset = 1'b0;
    model_clear();
    grow = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    reset = 1'b1;
    gblk = 5; grow = 0;
    feed(8, 1'b1);
    chk("t5_vec0", o_data, mkcol(5, 0));
    repeat (10) step(1'b0, 1'b1);

    // flush on the vector-3 handshake
    gblk = 6; grow = 0;
    feed(8, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("t6_vec3", o_data, mkcol(6, 3));
    flush = 1'b1;
    step(1'b0, 1'b1);
    flush = 1'b0;
    #1;
    chk("t6_ovalid", W'(o_valid), W'(1'b0));
    gblk = 7; grow = 0;
    feed(8, 1'b1);
    chk("t6_new_vec0", o_data, mkcol(7, 0));
    repeat (10) step(1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      flush    = ($urandom % 64) == 0;
      i_valid  = ($urandom % 4) != 0;
      o_ready  = ($urandom % 3) != 0;
      i_bypass = $urandom % 2;
      i_data   = W'({$urandom, $urandom, $urandom});
      cyc();
    end
    flush = 1'b0;
    repeat (20) step(1'b0, 1'b1);
    chk("end_empty", W'(o_valid), W'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
